// File: rtl/key_event_decoder.sv
// key_event_decoder
//   Turns a debounced key level into single-clock event pulses (press,
//   release, short, long, repeat). It also reports a held level and a
//   saturating count of scan ticks since the press.
//
//   State table
//     state      | meaning
//     IDLE       | key not held; hold_cnt keeps the length of the last hold
//     PRESSED    | key held, long-press threshold not reached yet
//     LONG       | key held past LONG_TICKS; auto-repeat running
//
//   Ports
//     clk          in   system clock, rising edge
//     rst          in   asynchronous active-high reset
//     tick         in   1-clk timebase strobe at the key scan rate
//     key_level    in   debounced key level, 1 = pressed
//     key_press    out  1-clk pulse on press
//     key_release  out  1-clk pulse on any release
//     key_short    out  1-clk pulse on release before long-press
//     key_long     out  1-clk pulse when the hold reaches LONG_TICKS
//     key_repeat   out  1-clk pulse every REPEAT_TICKS while in long hold
//     key_held     out  level, 1 while not IDLE
//     hold_cnt     out  ticks since press, saturating
module key_event_decoder #(
  parameter int LONG_TICKS   = 150,
  parameter int REPEAT_TICKS = 30,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             key_level,
  output logic             key_press,
  output logic             key_release,
  output logic             key_short,
  output logic             key_long,
  output logic             key_repeat,
  output logic             key_held,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_LONG    = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

  logic [1:0]       state_q,    state_d;
  logic             key_d_q,    key_d_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q,  rep_cnt_d;
  logic             press_q,    press_d;
  logic             release_q,  release_d;
  logic             short_q,    short_d;
  logic             long_q,     long_d;
  logic             repeat_q,   repeat_d;
  logic             held_q,     held_d;

  logic             press_edge;
  logic [CNT_W-1:0] hold_inc;

  assign press_edge = key_level & ~key_d_q;
  assign hold_inc   = (hold_cnt_q == CNT_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    key_d_d    = key_level;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    short_d    = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A tick in the press-edge cycle is deliberately not counted.
        if (press_edge) begin
          state_d    = ST_PRESSED;
          hold_cnt_d = '0;
          press_d    = 1'b1;
        end
      end
      ST_PRESSED: begin
        // Release is checked first so a coincident tick cannot fire key_long.
        if (!key_level) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          short_d   = 1'b1;
        end else if (tick) begin
          hold_cnt_d = hold_inc;
          if (hold_cnt_q == LONG_LAST) begin
            state_d   = ST_LONG;
            long_d    = 1'b1;
            rep_cnt_d = '0;
          end
        end
      end
      ST_LONG: begin
        if (!key_level) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end else if (tick) begin
          hold_cnt_d = hold_inc;
          if (rep_cnt_q == REP_LAST) begin
            repeat_d  = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    held_d = (state_d != ST_IDLE);
  end

  // key_d resets to 1 so a key held through reset is not seen as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      key_d_q    <= 1'b1;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_d_q    <= key_d_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      short_q    <= short_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
      held_q     <= held_d;
    end
  end

  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_short   = short_q;
  assign key_long    = long_q;
  assign key_repeat  = repeat_q;
  assign key_held    = held_q;
  assign hold_cnt    = hold_cnt_q;

endmodule

// File: tb/tb_key_event_decoder.sv
module tb_key_event_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       key_level;

  logic       key_press, key_release, key_short, key_long, key_repeat, key_held;
  logic [7:0] hold_cnt;
  logic       p3, r3, s3, l3, rp3, h3;
  logic [2:0] hold_cnt3;

  int checks = 0;
  int errors = 0;

  key_event_decoder #(.LONG_TICKS(4), .REPEAT_TICKS(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .tick(tick), .key_level(key_level),
    .key_press(key_press), .key_release(key_release), .key_short(key_short),
    .key_long(key_long), .key_repeat(key_repeat), .key_held(key_held),
    .hold_cnt(hold_cnt)
  );

  key_event_decoder #(.LONG_TICKS(4), .REPEAT_TICKS(2), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .tick(tick), .key_level(key_level),
    .key_press(p3), .key_release(r3), .key_short(s3),
    .key_long(l3), .key_repeat(rp3), .key_held(h3),
    .hold_cnt(hold_cnt3)
  );

  always #5 clk = ~clk;

  // Event monitor: counts pulses and records the tick index of long/repeat.
  int tick_cnt = 0;
  int press_cnt = 0, release_cnt = 0, short_cnt = 0, long_cnt = 0, rep_cnt = 0, both_cnt = 0;
  int long_at = 0;
  int rep_q[$];

  always @(posedge clk) if (tick && !rst) tick_cnt <= tick_cnt + 1;

  always @(negedge clk) begin
    if (key_press)   press_cnt   <= press_cnt + 1;
    if (key_release) release_cnt <= release_cnt + 1;
    if (key_short)   short_cnt   <= short_cnt + 1;
    if (key_long) begin
      long_cnt <= long_cnt + 1;
      long_at  <= tick_cnt;
    end
    if (key_repeat) begin
      rep_cnt <= rep_cnt + 1;
      rep_q.push_back(tick_cnt);
    end
    if (key_long && key_repeat) both_cnt <= both_cnt + 1;
  end

  int b_tick, b_press, b_rel, b_short, b_long, b_rep, b_repq;

  task automatic snap();
    b_tick = tick_cnt; b_press = press_cnt; b_rel = release_cnt;
    b_short = short_cnt; b_long = long_cnt; b_rep = rep_cnt; b_repq = rep_q.size();
  endtask

  // One clock: inputs applied 1 ns after a falling edge, held to the next one.
  task automatic cyc(input logic lvl, input logic tk);
    key_level = lvl;
    tick      = tk;
    @(negedge clk);
    #1;
  endtask

  task automatic hold_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    checks++;
    if ({key_press, key_release, key_short, key_long, key_repeat, key_held} !== 6'b0) begin
      errors++; $display("FAIL reset_events got %b want 000000",
        {key_press, key_release, key_short, key_long, key_repeat, key_held});
    end
    checks++;
    if (hold_cnt !== 8'd0) begin errors++; $display("FAIL reset_hold_cnt got %0d want 0", hold_cnt); end
    @(negedge clk); #1;
    rst = 1'b0;
    idle(3);
  endtask

  task automatic test_short_press();
    snap();
    cyc(1'b1, 1'b0);
    checks++;
    if (key_press !== 1'b1 || key_held !== 1'b1 || hold_cnt !== 8'd0) begin
      errors++; $display("FAIL press_latency got press=%b held=%b cnt=%0d want 1 1 0", key_press, key_held, hold_cnt);
    end
    cyc(1'b1, 1'b0);
    checks++;
    if (key_press !== 1'b0) begin errors++; $display("FAIL press_width got %b want 0", key_press); end
    hold_ticks(3);
    idle(3);
    checks++;
    if (press_cnt - b_press !== 1) begin errors++; $display("FAIL short_press_cnt got %0d want 1", press_cnt - b_press); end
    checks++;
    if (short_cnt - b_short !== 1 || release_cnt - b_rel !== 1) begin
      errors++; $display("FAIL short_events got short=%0d rel=%0d want 1 1", short_cnt - b_short, release_cnt - b_rel);
    end
    checks++;
    if (long_cnt - b_long !== 0) begin errors++; $display("FAIL short_no_long got %0d want 0", long_cnt - b_long); end
    checks++;
    if (hold_cnt !== 8'd3 || key_held !== 1'b0) begin
      errors++; $display("FAIL short_hold_cnt got cnt=%0d held=%b want 3 0", hold_cnt, key_held);
    end
  endtask

  task automatic test_long_repeat();
    snap();
    cyc(1'b1, 1'b0);
    hold_ticks(9);
    checks++;
    if (key_held !== 1'b1 || hold_cnt !== 8'd9) begin
      errors++; $display("FAIL long_held got held=%b cnt=%0d want 1 9", key_held, hold_cnt);
    end
    idle(3);
    checks++;
    if (long_cnt - b_long !== 1 || long_at - b_tick !== 4) begin
      errors++; $display("FAIL long_event got cnt=%0d at=%0d want 1 4", long_cnt - b_long, long_at - b_tick);
    end
    checks++;
    if (rep_cnt - b_rep !== 2) begin
      errors++; $display("FAIL repeat_cnt got %0d want 2", rep_cnt - b_rep);
    end else begin
      checks++;
      if (rep_q[b_repq] - b_tick !== 6 || rep_q[b_repq+1] - b_tick !== 8) begin
        errors++; $display("FAIL repeat_ticks got %0d,%0d want 6,8", rep_q[b_repq] - b_tick, rep_q[b_repq+1] - b_tick);
      end
    end
    checks++;
    if (release_cnt - b_rel !== 1 || short_cnt - b_short !== 0) begin
      errors++; $display("FAIL long_release got rel=%0d short=%0d want 1 0", release_cnt - b_rel, short_cnt - b_short);
    end
    checks++;
    if (hold_cnt !== 8'd9) begin errors++; $display("FAIL long_hold_cnt got %0d want 9", hold_cnt); end
    checks++;
    if (both_cnt !== 0) begin errors++; $display("FAIL long_repeat_overlap got %0d want 0", both_cnt); end
  endtask

  task automatic test_release_on_tick();
    snap();
    cyc(1'b1, 1'b0);
    hold_ticks(3);
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    idle(3);
    checks++;
    if (release_cnt - b_rel !== 1 || short_cnt - b_short !== 1 || long_cnt - b_long !== 0) begin
      errors++; $display("FAIL release_tick got rel=%0d short=%0d long=%0d want 1 1 0",
        release_cnt - b_rel, short_cnt - b_short, long_cnt - b_long);
    end
    checks++;
    if (hold_cnt !== 8'd3) begin errors++; $display("FAIL release_tick_cnt got %0d want 3", hold_cnt); end
  endtask

  task automatic test_saturation();
    cyc(1'b1, 1'b0);
    hold_ticks(12);
    checks++;
    if (hold_cnt3 !== 3'd7) begin errors++; $display("FAIL sat_cnt_w3 got %0d want 7", hold_cnt3); end
    checks++;
    if (hold_cnt !== 8'd12) begin errors++; $display("FAIL sat_cnt_w8 got %0d want 12", hold_cnt); end
    idle(2);
    checks++;
    if (hold_cnt3 !== 3'd7) begin errors++; $display("FAIL sat_idle_w3 got %0d want 7", hold_cnt3); end
  endtask

  task automatic test_glitch();
    idle(2);
    snap();
    cyc(1'b1, 1'b0);
    checks++;
    if (key_press !== 1'b1 || key_release !== 1'b0) begin
      errors++; $display("FAIL glitch_press got press=%b rel=%b want 1 0", key_press, key_release);
    end
    cyc(1'b0, 1'b0);
    checks++;
    if (key_press !== 1'b0 || key_release !== 1'b1 || key_short !== 1'b1) begin
      errors++; $display("FAIL glitch_release got press=%b rel=%b short=%b want 0 1 1", key_press, key_release, key_short);
    end
    cyc(1'b0, 1'b0);
    checks++;
    if (key_release !== 1'b0 || key_held !== 1'b0) begin
      errors++; $display("FAIL glitch_width got rel=%b held=%b want 0 0", key_release, key_held);
    end
  endtask

  task automatic test_reset_mid_hold();
    idle(2);
    cyc(1'b1, 1'b0);
    hold_ticks(5);
    snap();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({key_press, key_release, key_short, key_long, key_repeat, key_held} !== 6'b0 || hold_cnt !== 8'd0) begin
      errors++; $display("FAIL async_reset got ev=%b cnt=%0d want 000000 0",
        {key_press, key_release, key_short, key_long, key_repeat, key_held}, hold_cnt);
    end
    @(negedge clk); #1;
    cyc(1'b1, 1'b0);
    rst = 1'b0;
    hold_ticks(6);
    checks++;
    if (key_held !== 1'b0 || hold_cnt !== 8'd0) begin
      errors++; $display("FAIL held_through_reset got held=%b cnt=%0d want 0 0", key_held, hold_cnt);
    end
    idle(3);
    checks++;
    if (press_cnt - b_press !== 0 || release_cnt - b_rel !== 0 || short_cnt - b_short !== 0 ||
        long_cnt - b_long !== 0 || rep_cnt - b_rep !== 0) begin
      errors++; $display("FAIL post_reset_events got p=%0d r=%0d s=%0d l=%0d rp=%0d want all 0",
        press_cnt - b_press, release_cnt - b_rel, short_cnt - b_short, long_cnt - b_long, rep_cnt - b_rep);
    end
    cyc(1'b1, 1'b0);
    checks++;
    if (key_press !== 1'b1 || key_held !== 1'b1) begin
      errors++; $display("FAIL repress_after_reset got press=%b held=%b want 1 1", key_press, key_held);
    end
    idle(3);
  endtask

  initial begin
    rst = 1'b1;
    tick = 1'b0;
    key_level = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    test_short_press();
    test_long_repeat();
    test_release_on_tick();
    test_saturation();
    test_glitch();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
